// File: rtl/mmio_timer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, level irq.
// Optional MMIO_TIMER_SNAPSHOT_EN adds a shadow of mtime[63:32] captured on MTIME_LO reads.
module mmio_timer #(
    parameter int            AW        = 32,
    parameter int            DW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] address,
    input  logic          read,
    input  logic          write,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          timer_irq
);
    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_PRESCALE = 3'd5;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        en;
    logic [31:0] prescale;
    logic [31:0] cnt;
    logic [31:0] mtime_hi_rd;

    logic        hit;
    logic [2:0]  offset;
    logic        wr;
    logic        tick;
    logic        unused_addr;

    assign hit         = (address[AW-1:5] == BASE_ADDR[AW-1:5]);
    assign offset      = address[4:2];
    assign wr          = write && hit;
    assign tick        = en && (cnt == prescale);
    assign unused_addr = ^address[1:0];

    // A software write to either mtime word wins over the tick in that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime <= '0;
        end else if (wr && offset == OFF_MTIME_LO) begin
            mtime[31:0] <= wdata;
        end else if (wr && offset == OFF_MTIME_HI) begin
            mtime[63:32] <= wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtimecmp <= '1;
            en       <= 1'b0;
            prescale <= '0;
        end else if (wr) begin
            case (offset)
                OFF_CMP_LO:   mtimecmp[31:0]  <= wdata;
                OFF_CMP_HI:   mtimecmp[63:32] <= wdata;
                OFF_CTRL:     en              <= wdata[0];
                OFF_PRESCALE: prescale        <= wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (wr && (offset == OFF_MTIME_LO || offset == OFF_MTIME_HI ||
                            offset == OFF_CTRL     || offset == OFF_PRESCALE)) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? 32'd0 : cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) timer_irq <= 1'b0;
        else          timer_irq <= (mtime >= mtimecmp);
    end

`ifdef MMIO_TIMER_SNAPSHOT_EN
    logic [31:0] shadow_hi;

    // Shadow tracks the post-write high word so a following HI read stays coherent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_hi <= '0;
        end else if (wr && offset == OFF_MTIME_HI) begin
            shadow_hi <= wdata;
        end else if ((wr && offset == OFF_MTIME_LO) ||
                     (read && hit && offset == OFF_MTIME_LO)) begin
            shadow_hi <= mtime[63:32];
        end
    end

    assign mtime_hi_rd = shadow_hi;
`else
    assign mtime_hi_rd = mtime[63:32];
`endif

    always_comb begin
        rdata = '0;
        if (read && hit) begin
            case (offset)
                OFF_MTIME_LO: rdata = mtime[31:0];
                OFF_MTIME_HI: rdata = mtime_hi_rd;
                OFF_CMP_LO:   rdata = mtimecmp[31:0];
                OFF_CMP_HI:   rdata = mtimecmp[63:32];
                OFF_CTRL:     rdata = {31'd0, en};
                OFF_PRESCALE: rdata = prescale;
                default:      rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer; expectations follow MMIO_TIMER_SNAPSHOT_EN when defined.
module tb_mmio_timer;
    localparam logic [31:0] A_LO   = 32'h0200_0000;
    localparam logic [31:0] A_HI   = 32'h0200_0004;
    localparam logic [31:0] A_CLO  = 32'h0200_0008;
    localparam logic [31:0] A_CHI  = 32'h0200_000C;
    localparam logic [31:0] A_CTRL = 32'h0200_0010;
    localparam logic [31:0] A_PS   = 32'h0200_0014;
    localparam logic [31:0] A_R18  = 32'h0200_0018;
    localparam logic [31:0] A_R1C  = 32'h0200_001C;
    localparam logic [31:0] A_MISS = 32'h0200_0020;

    logic        clk;
    logic        reset_n;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] d;

    mmio_timer dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .wdata(wdata), .rdata(rdata), .timer_irq(timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Each bus access occupies one clock edge, as the single-cycle core would.
    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        address = a; wdata = v; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        address = a; read = 1'b1;
        #1 v = rdata;
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        address = a; read = 1'b1;
        #1 v = rdata;
        read = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; address = '0; read = 1'b0; write = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        rd(A_CLO, d); chk("rst_cmp_lo", d, 32'hFFFF_FFFF);
        rd(A_CHI, d); chk("rst_cmp_hi", d, 32'hFFFF_FFFF);
        chk("rst_irq", {31'd0, timer_irq}, 32'd0);
        rd(A_LO, d);  chk("rst_mtime_lo", d, 32'd0);
        address = A_CLO; read = 1'b0;
        #1 chk("rdata_idle", rdata, 32'd0);

        // PRESCALE=0: one tick per cycle after enable
        wr(A_CTRL, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        rd(A_LO, d); chk("ps0_10cyc", d, 32'd10);
        wr(A_CTRL, 32'd0);
        rd(A_LO, d); chk("stopped", d, 32'd12);

        // PRESCALE=3: one tick every 4 cycles
        wr(A_PS, 32'd3);
        wr(A_CTRL, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        rd(A_LO, d); chk("ps3_20cyc", d, 32'd17);

        // LO->HI carry
        wr(A_CTRL, 32'd0);
        wr(A_PS, 32'd0);
        wr(A_LO, 32'hFFFF_FFFE);
        wr(A_HI, 32'd0);
        wr(A_CTRL, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rd(A_LO, d); chk("carry_lo", d, 32'd1);
        rd(A_HI, d); chk("carry_hi", d, 32'd1);

        // Compare / interrupt latency
        wr(A_CTRL, 32'd0);
        wr(A_HI, 32'd0);
        wr(A_LO, 32'd90);
        wr(A_CLO, 32'd100);
        wr(A_CHI, 32'd0);
        wr(A_CTRL, 32'd1);
        repeat (10) @(posedge clk);
        #1 chk("irq_at_100", {31'd0, timer_irq}, 32'd0);
        @(posedge clk);
        #1 chk("irq_rise", {31'd0, timer_irq}, 32'd1);
        wr(A_CHI, 32'd1);
        chk("irq_hold", {31'd0, timer_irq}, 32'd1);
        @(posedge clk);
        #1 chk("irq_fall", {31'd0, timer_irq}, 32'd0);

        // Software write beats a due tick
        wr(A_LO, 32'd5);
        rd(A_LO, d); chk("wr_vs_tick", d, 32'd5);
        wr(A_CTRL, 32'd0);
        rd(A_LO, d); chk("after_stop", d, 32'd7);

        // Reserved / out-of-window accesses, CTRL bit masking
        wr(A_MISS, 32'hDEAD_BEEF);
        wr(A_R18, 32'h1234_5678);
        rd(A_R18, d);  chk("rsvd18", d, 32'd0);
        rd(A_R1C, d);  chk("rsvd1c", d, 32'd0);
        rd(A_MISS, d); chk("miss", d, 32'd0);
        rd(A_LO, d);   chk("miss_no_wr", d, 32'd7);
        rd(A_PS, d);   chk("ps_intact", d, 32'd0);
        rd(A_CHI, d);  chk("cmphi_intact", d, 32'd1);
        wr(A_CTRL, 32'hFFFF_FFFE);
        rd(A_CTRL, d); chk("ctrl_mask0", d, 32'd0);

        // Tear-free 64-bit read
        wr(A_HI, 32'd0);
        wr(A_LO, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'd1);
        rd(A_LO, d); chk("snap_lo", d, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        rd(A_HI, d);
`ifdef MMIO_TIMER_SNAPSHOT_EN
        chk("snap_hi", d, 32'd0);
`else
        chk("snap_hi", d, 32'd1);
`endif

        // Async reset mid-count with irq asserted
        wr(A_CHI, 32'd0);
        @(posedge clk);
        #1 chk("irq_pre_rst", {31'd0, timer_irq}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("irq_async_rst", {31'd0, timer_irq}, 32'd0);
        peek(A_LO, d);   chk("rst2_lo", d, 32'd0);
        peek(A_HI, d);   chk("rst2_hi", d, 32'd0);
        peek(A_CLO, d);  chk("rst2_cmp_lo", d, 32'hFFFF_FFFF);
        peek(A_CHI, d);  chk("rst2_cmp_hi", d, 32'hFFFF_FFFF);
        peek(A_CTRL, d); chk("rst2_ctrl", d, 32'd0);
        peek(A_PS, d);   chk("rst2_ps", d, 32'd0);
        #3 reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped machine timer that responds on the core's data-master bus (address/MemRead/MemWrite/wdata/rdata) as a slave alongside data memory.
- Provides a 64-bit mtime counter with prescaler and a 64-bit mtimecmp register.
- Drives a level timer interrupt when mtime >= mtimecmp.
- Read data is combinational, so the single-cycle core completes loads in the same cycle; all state updates occur on the rising clock edge.

Parameters:
- AW, 32, bus address width.
- DW, 32, bus data width; only 32 is supported.
- BASE_ADDR, 32'h0200_0000, base of a 32-byte register window; must be 32-byte aligned.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- address  input  AW  byte address from the core's data master.
- read  input  1  load strobe (MemRead).
- write  input  1  store strobe (MemWrite).
- wdata  input  DW  store data.
- rdata  output  DW  load data, combinational.
- timer_irq  output  1  registered level interrupt.

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Decode:
  - hit = (address[AW-1:5] == BASE_ADDR[AW-1:5]).
  - offset = address[4:2]; address[1:0] is ignored, and all accesses are full 32-bit words.
- Register map:
  - 0x00 MTIME_LO, rw.
  - 0x04 MTIME_HI, rw.
  - 0x08 MTIMECMP_LO, rw.
  - 0x0C MTIMECMP_HI, rw.
  - 0x10 CTRL: bit0 EN; other bits read 0, writes to them ignored.
  - 0x14 PRESCALE, rw, 32 bits.
  - 0x18 and 0x1C: reserved; read 0, writes ignored.
- Reset values:
  - mtime = 0.
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - CTRL = 0, PRESCALE = 0, internal prescale count = 0, timer_irq = 0.
- rdata:
  - When read && hit: the selected register's current value.
  - Otherwise: 32'h0, including when read is low.
  - Reads have no side effects.
- Writes: when write && hit, the selected register takes wdata at the next rising edge. When write is asserted with no hit, there is no effect.
- Read and write in the same cycle: rdata returns the pre-write value; the write lands at the edge.
- Tick generation:
  - When EN=1, the prescale count increments each cycle.
  - When count == PRESCALE, count returns to 0 and mtime increments by 1 (64-bit, wraps FFFF..F -> 0).
  - PRESCALE=0 gives an increment every cycle.
  - When EN=0, both count and mtime hold.
- Writing PRESCALE or CTRL clears the prescale count to 0.
- Software write vs. tick in the same cycle:
  - A write to MTIME_LO or MTIME_HI suppresses that cycle's increment entirely.
  - The written word takes wdata, the other word holds, and the prescale count resets to 0.
- Carry: increments are full 64-bit; the LO -> HI carry takes effect in the same edge.
- Interrupt:
  - timer_irq <= (mtime >= mtimecmp), unsigned 64-bit compare on the current register values.
  - Latency is one cycle after the condition becomes true in registers.
  - The output is level only; it deasserts one cycle after software raises mtimecmp above mtime or lowers mtime.
- Reset mid-operation: all state returns immediately to reset values; timer_irq drops asynchronously.

Optional Feature:
- Macro: MMIO_TIMER_SNAPSHOT_EN.
- When defined:
  - A read of MTIME_LO (read && hit && offset 0) captures the current mtime[63:32] into a shadow register at that edge.
  - Subsequent MTIME_HI reads return the shadow, not live mtime[63:32], giving a tear-free 64-bit read with LO read first.
  - The shadow resets to 0.
  - Any write to MTIME_LO or MTIME_HI also loads the shadow with the resulting mtime[63:32].
- When undefined: MTIME_HI reads always return live mtime[63:32], and no shadow register exists.

Test Plan:
- Reset then read 0x0200_0008 and 0x0200_000C -> rdata 32'hFFFF_FFFF both; timer_irq 0; MTIME_LO reads 0.
- Write CTRL=1 with PRESCALE=0, wait 10 cycles, read MTIME_LO -> 10; with PRESCALE=3, 20 cycles after the CTRL write -> MTIME_LO advances by exactly 5.
- Write MTIME_LO=32'hFFFF_FFFE and MTIME_HI=0, EN=1, PRESCALE=0, run 3 cycles -> MTIME_HI=1 and MTIME_LO=1 (carry verified).
- MTIMECMP={0,100}, MTIME=90, EN=1, PRESCALE=0 -> timer_irq rises exactly 1 cycle after mtime reaches 100; then write MTIMECMP_HI=1 -> irq falls next cycle.
- Write MTIME_LO=5 in the same cycle a tick is due -> MTIME_LO reads 5 next cycle, not 6; access to 0x0200_0020 or offset 0x18 -> rdata 0 and no register changes.
- SNAPSHOT_EN: mtime={0,FFFF_FFFF}, read LO, wait 2 cycles (HI becomes 1), read HI -> 0; without the macro -> 1. Assert reset_n low mid-count -> all registers at reset values with no clock edge.
